// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: load/store funct3 encodings and
// the data-memory responder state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one load/store access: write enables and data
// replication, read extraction with sign/zero extension, and access legality.
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [7:0]  rByte;
  logic [15:0] rHalf;
  logic [3:0]  byteLane;

  always_comb begin
    rByte    = rword_i[7:0];
    byteLane = 4'b0001;
    case (addr_lo_i)
      2'd1: begin rByte = rword_i[15:8];  byteLane = 4'b0010; end
      2'd2: begin rByte = rword_i[23:16]; byteLane = 4'b0100; end
      2'd3: begin rByte = rword_i[31:24]; byteLane = 4'b1000; end
      default: begin rByte = rword_i[7:0]; byteLane = 4'b0001; end
    endcase
    rHalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o    = byteLane;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{rByte[7]}}, rByte};
      end
      F3_H: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{rHalf[15]}}, rHalf};
      end
      F3_W: begin
        misalign_o = (addr_lo_i != 2'b00);
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
      F3_BU: begin
        illegal_o = we_i;
        rdata_o   = {24'h0, rByte};
      end
      F3_HU: begin
        misalign_o = addr_lo_i[0];
        illegal_o  = we_i;
        rdata_o    = {16'h0, rHalf};
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: single-outstanding load/store into a word RAM with
// optional wait states and a registered response held until handshake.
module data_mem_resp
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] ram [DEPTH_WORDS];

  logic [AW-1:0] wordIdx;
  logic [31:0]   rdWord;
  logic [3:0]    byteEn;
  logic [31:0]   wrData;
  logic [31:0]   loadData;
  logic          misalign;
  logic          illegal;
  logic          outOfRange;
  logic          accessErr;
  logic          accept;

  assign wordIdx    = req_addr[AW+1:2];
  assign outOfRange = |(req_addr >> (AW + 2));
  assign rdWord     = ram[wordIdx];
  assign accessErr  = misalign | illegal | outOfRange;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  mem_lane_align u_align (
    .we_i      (req_we),
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .wdata_i   (req_wdata),
    .rword_i   (rdWord),
    .be_o      (byteEn),
    .wdata_o   (wrData),
    .rdata_o   (loadData),
    .misalign_o(misalign),
    .illegal_o (illegal)
  );

  // The load result is captured at acceptance, so wait states never see later RAM changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (req_we || accessErr) ? 32'h0 : loadData;
          err_d   = accessErr;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset; a faulting access never writes.
  always_ff @(posedge clock) begin
    if (accept && req_we && !accessErr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) ram[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with no wait states and one
// with three, sharing clock and reset.
module tb_data_mem_resp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid [2];
  logic        reqReady [2];
  logic        reqWe    [2];
  logic [2:0]  reqF3    [2];
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWdata [2];
  logic        rspValid [2];
  logic        rspReady [2];
  logic [31:0] rspRdata [2];
  logic        rspErr   [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clock = ~clock;

  data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
    .req_funct3(reqF3[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
    .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );

  data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
    .req_funct3(reqF3[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
    .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction with rsp_ready high; lat counts falling edges after acceptance until rsp_valid.
  task automatic applyStimulus(input int s, input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] rdo, output logic ero, output int lato);
    @(negedge clock);
    reqValid[s] = 1'b1;
    reqWe[s]    = we;
    reqF3[s]    = f3;
    reqAddr[s]  = a;
    reqWdata[s] = wd;
    rspReady[s] = 1'b1;
    @(posedge clock);
    #1;
    reqValid[s] = 1'b0;
    lato = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (rspValid[s]) begin
        lato = i;
        break;
      end
    end
    rdo = rspRdata[s];
    ero = rspErr[s];
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 1'b0;
      reqWe[s]    = 1'b0;
      reqF3[s]    = 3'b010;
      reqAddr[s]  = 32'h0;
      reqWdata[s] = 32'h0;
      rspReady[s] = 1'b0;
    end

    repeat (2) @(negedge clock);
    checkOutput("reset_req_ready", 32'(reqReady[0]), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rspValid[0]), 32'd0);
    checkOutput("reset_rsp_rdata", rspRdata[0], 32'h0);
    checkOutput("reset_rsp_err",   32'(rspErr[0]), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle_req_ready", 32'(reqReady[0]), 32'd1);

    applyStimulus(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checkOutput("sw_rdata", rd, 32'h0);
    checkOutput("sw_err",   32'(er), 32'd0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checkOutput("lw_rdata",   rd, 32'hDEADBEEF);
    checkOutput("lw_err",     32'(er), 32'd0);
    checkOutput("lw_latency", 32'(lat), 32'd1);

    applyStimulus(0, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
    checkOutput("lb_13", rd, 32'hFFFFFFDE);
    applyStimulus(0, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
    checkOutput("lbu_13", rd, 32'h000000DE);
    applyStimulus(0, 1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
    checkOutput("lh_12", rd, 32'hFFFFDEAD);
    applyStimulus(0, 1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat);
    checkOutput("lhu_10", rd, 32'h0000BEEF);
    applyStimulus(0, 1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    checkOutput("lb_10", rd, 32'hFFFFFFEF);

    applyStimulus(0, 1'b1, 3'b000, 32'h11, 32'h00000055, rd, er, lat);
    checkOutput("sb_err", 32'(er), 32'd0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checkOutput("lw_after_sb", rd, 32'hDEAD55EF);

    applyStimulus(0, 1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat);
    checkOutput("lw_mis_err",   32'(er), 32'd1);
    checkOutput("lw_mis_rdata", rd, 32'h0);
    applyStimulus(0, 1'b1, 3'b001, 32'h11, 32'h0000AAAA, rd, er, lat);
    checkOutput("sh_mis_err", 32'(er), 32'd1);
    applyStimulus(0, 1'b1, 3'b100, 32'h10, 32'h11111111, rd, er, lat);
    checkOutput("store_f3_bad_err", 32'(er), 32'd1);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checkOutput("lw_after_bad_stores", rd, 32'hDEAD55EF);
    applyStimulus(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    checkOutput("load_f3_011_err",   32'(er), 32'd1);
    checkOutput("load_f3_011_rdata", rd, 32'h0);
    applyStimulus(0, 1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
    checkOutput("lw_range_err", 32'(er), 32'd1);

    applyStimulus(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, rd, er, lat);
    checkOutput("ws3_sw_latency", 32'(lat), 32'd4);

    @(negedge clock);
    reqValid[1] = 1'b1;
    reqWe[1]    = 1'b0;
    reqF3[1]    = 3'b010;
    reqAddr[1]  = 32'h40;
    rspReady[1] = 1'b0;
    @(posedge clock);
    #1;
    reqValid[1] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      checkOutput("ws3_valid_early", 32'(rspValid[1]), 32'd0);
      checkOutput("ws3_ready_wait",  32'(reqReady[1]), 32'd0);
    end
    @(negedge clock);
    checkOutput("ws3_valid_on_time", 32'(rspValid[1]), 32'd1);
    checkOutput("ws3_rdata",         rspRdata[1], 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("ws3_hold_valid", 32'(rspValid[1]), 32'd1);
      checkOutput("ws3_hold_rdata", rspRdata[1], 32'hCAFEF00D);
      checkOutput("ws3_hold_ready", 32'(reqReady[1]), 32'd0);
    end
    rspReady[1] = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("ws3_post_hs_valid", 32'(rspValid[1]), 32'd0);
    checkOutput("ws3_post_hs_ready", 32'(reqReady[1]), 32'd1);

    @(negedge clock);
    reqValid[1] = 1'b1;
    reqWe[1]    = 1'b1;
    reqF3[1]    = 3'b010;
    reqAddr[1]  = 32'h20;
    reqWdata[1] = 32'h12345678;
    @(posedge clock);
    #1;
    reqValid[1] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rst_wait_valid", 32'(rspValid[1]), 32'd0);
    checkOutput("rst_wait_ready", 32'(reqReady[1]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    checkOutput("rst_store_kept", rd, 32'h12345678);
    checkOutput("rst_lw_latency", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
